// File: rtl/pmod_als_spi_responder.sv
// Pmod ALS ADC stand-in: shifts a DATA_BITS word out on sdo, MSB first,
// in response to an external SPI master's cs/sck.
module pmod_als_spi_responder #(
  parameter int DATA_BITS   = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 cs,
  input  logic                 sck,
  output logic                 sdo,
  input  logic [DATA_BITS-1:0] value,
  output logic                 busy,
  output logic                 frame_done,
  output logic                 frame_error,
  output logic [7:0]           frame_count
);

  localparam int CW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] FULL = CW'(DATA_BITS);

  typedef enum logic {IDLE, SHIFT} state_t;

  logic [SYNC_STAGES-1:0] cs_sync;
  logic [SYNC_STAGES-1:0] sck_sync;
  logic                   cs_hist;
  logic                   sck_hist;
  logic [SYNC_STAGES:0]   vld;
  logic                   cs_s;
  logic                   sck_s;
  logic                   live;
  logic                   cs_fall_q;
  logic                   cs_rise_q;
  logic                   sck_fall_q;

  state_t                 state;
  logic [DATA_BITS-1:0]   shreg;
  logic [CW-1:0]          cnt;

  assign cs_s  = cs_sync[SYNC_STAGES-1];
  assign sck_s = sck_sync[SYNC_STAGES-1];
  // History flop only reflects the real pin once the reset ones have drained,
  // so a cs held low across reset never looks like a falling edge.
  assign live  = vld[SYNC_STAGES];

  always_ff @(posedge clock) begin
    if (reset) begin
      cs_sync    <= '1;
      sck_sync   <= '1;
      cs_hist    <= 1'b1;
      sck_hist   <= 1'b1;
      vld        <= '0;
      cs_fall_q  <= 1'b0;
      cs_rise_q  <= 1'b0;
      sck_fall_q <= 1'b0;
    end else begin
      cs_sync    <= {cs_sync[SYNC_STAGES-2:0], cs};
      sck_sync   <= {sck_sync[SYNC_STAGES-2:0], sck};
      cs_hist    <= cs_s;
      sck_hist   <= sck_s;
      vld        <= {vld[SYNC_STAGES-1:0], 1'b1};
      cs_fall_q  <= live & cs_hist & ~cs_s;
      cs_rise_q  <= live & ~cs_hist & cs_s;
      sck_fall_q <= live & sck_hist & ~sck_s;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      shreg       <= '0;
      cnt         <= '0;
      sdo         <= 1'b0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      frame_error <= 1'b0;
      frame_count <= '0;
    end else begin
      frame_done  <= 1'b0;
      frame_error <= 1'b0;
      unique case (state)
        IDLE: begin
          sdo  <= 1'b0;
          busy <= 1'b0;
          if (cs_fall_q) begin
            state <= SHIFT;
            busy  <= 1'b1;
            shreg <= value;
            cnt   <= '0;
          end
        end
        SHIFT: begin
          busy <= 1'b1;
          if (cs_rise_q) begin
            state <= IDLE;
            busy  <= 1'b0;
            sdo   <= 1'b0;
            if (cnt == FULL) begin
              frame_done  <= 1'b1;
              frame_count <= frame_count + 8'd1;
            end else begin
              frame_error <= 1'b1;
            end
          end else if (sck_fall_q) begin
            if (cnt != FULL) begin
              sdo   <= shreg[DATA_BITS-1];
              shreg <= {shreg[DATA_BITS-2:0], 1'b0};
              cnt   <= cnt + CW'(1);
            end else begin
              sdo <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pmod_als_spi_responder.sv
// Bench for pmod_als_spi_responder: task-based SPI master, vector table,
// expected-word queue, plus idle-toggle and mid-frame reset sequences.
module tb_pmod_als_spi_responder;

  logic        clock;
  logic        reset;
  logic        cs;
  logic        sck;
  logic        sdo;
  logic [15:0] value;
  logic        busy;
  logic        frame_done;
  logic        frame_error;
  logic [7:0]  frame_count;

  int n_checks;
  int n_fail;
  int done_n;
  int err_n;

  typedef struct {
    logic [15:0] v;
    logic [15:0] v2;
    int          sw;
    int          nf;
    logic [31:0] exp_rx;
    int          exp_done;
    int          exp_err;
  } vec_t;

  vec_t        tbl[8];
  logic [31:0] exp_q[$];
  logic [7:0]  exp_count;

  pmod_als_spi_responder #(
    .DATA_BITS(16),
    .SYNC_STAGES(2)
  ) dut (
    .clock(clock),
    .reset(reset),
    .cs(cs),
    .sck(sck),
    .sdo(sdo),
    .value(value),
    .busy(busy),
    .frame_done(frame_done),
    .frame_error(frame_error),
    .frame_count(frame_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (!reset) begin
      if (frame_done) done_n++;
      if (frame_error) err_n++;
    end
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Master: 8-clock half period, samples sdo on the cycle before sck rises.
  task automatic run_frame(input logic [15:0] v, input logic [15:0] v2,
                           input int sw, input int nf,
                           output logic [31:0] rx, output logic mb);
    rx = '0;
    mb = 1'b0;
    value = v;
    cs = 1'b0;
    repeat (8) @(negedge clock);
    for (int i = 0; i < nf; i++) begin
      sck = 1'b0;
      if (i + 1 == sw) value = v2;
      repeat (8) @(negedge clock);
      rx = {rx[30:0], sdo};
      if (i == nf / 2) mb = busy;
      sck = 1'b1;
      repeat (8) @(negedge clock);
    end
    cs = 1'b1;
    repeat (12) @(negedge clock);
  endtask

  task automatic frame_check(input string nm, input logic [15:0] v,
                             input logic [15:0] v2, input int sw,
                             input int nf, input logic [31:0] exp_rx,
                             input int exp_done, input int exp_err);
    logic [31:0] rx;
    logic [31:0] want;
    logic        mb;
    int          d0;
    int          e0;
    exp_q.push_back(exp_rx);
    d0 = done_n;
    e0 = err_n;
    run_frame(v, v2, sw, nf, rx, mb);
    if (exp_done != 0) exp_count = exp_count + 8'd1;
    want = exp_q.pop_front();
    chk({nm, "_rx"}, rx, want);
    chk({nm, "_done"}, done_n - d0, exp_done);
    chk({nm, "_err"}, err_n - e0, exp_err);
    chk({nm, "_count"}, {24'd0, frame_count}, {24'd0, exp_count});
    chk({nm, "_midbusy"}, {31'd0, mb}, 32'd1);
    chk({nm, "_sdo"}, {31'd0, sdo}, 32'd0);
    chk({nm, "_busy"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    logic [31:0] rx;
    logic        mb;
    int          d0;
    int          e0;
    int          viol;

    n_checks  = 0;
    n_fail    = 0;
    done_n    = 0;
    err_n     = 0;
    exp_count = 8'd0;

    tbl[0] = '{16'hA5C3, 16'hA5C3, 0, 16, 32'h0000A5C3, 1, 0};
    tbl[1] = '{16'h0001, 16'h0001, 0, 16, 32'h00000001, 1, 0};
    tbl[2] = '{16'hFFFF, 16'hFFFF, 0, 16, 32'h0000FFFF, 1, 0};
    tbl[3] = '{16'h8000, 16'h8000, 0, 16, 32'h00008000, 1, 0};
    tbl[4] = '{16'hBEEF, 16'hBEEF, 0, 5, 32'h00000017, 0, 1};
    tbl[5] = '{16'h1234, 16'h1234, 0, 16, 32'h00001234, 1, 0};
    tbl[6] = '{16'h00FF, 16'hFF00, 4, 16, 32'h000000FF, 1, 0};
    tbl[7] = '{16'hA5A5, 16'hA5A5, 0, 20, 32'h000A5A50, 1, 0};

    reset = 1'b1;
    cs    = 1'b1;
    sck   = 1'b1;
    value = 16'h0;
    repeat (3) @(negedge clock);
    chk("rst_sdo", {31'd0, sdo}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, frame_done}, 32'd0);
    chk("rst_err", {31'd0, frame_error}, 32'd0);
    chk("rst_count", {24'd0, frame_count}, 32'd0);
    reset = 1'b0;
    repeat (10) @(negedge clock);

    for (int k = 0; k < 8; k++)
      frame_check($sformatf("vec%0d", k), tbl[k].v, tbl[k].v2, tbl[k].sw,
                  tbl[k].nf, tbl[k].exp_rx, tbl[k].exp_done,
                  tbl[k].exp_err);

    // sck activity with cs deasserted must be ignored
    d0 = done_n;
    e0 = err_n;
    viol = 0;
    cs = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      if (i % 3 == 0) sck = ~sck;
      @(negedge clock);
      if (sdo !== 1'b0 || busy !== 1'b0) viol++;
    end
    sck = 1'b1;
    repeat (10) @(negedge clock);
    chk("idle_viol", viol, 0);
    chk("idle_pulses", (done_n - d0) + (err_n - e0), 0);
    chk("idle_count", {24'd0, frame_count}, {24'd0, exp_count});

    // reset after 8 shifts while cs stays low
    value = 16'hFFFF;
    cs = 1'b0;
    repeat (8) @(negedge clock);
    for (int i = 0; i < 8; i++) begin
      sck = 1'b0;
      repeat (8) @(negedge clock);
      sck = 1'b1;
      repeat (8) @(negedge clock);
    end
    d0 = done_n;
    e0 = err_n;
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    exp_count = 8'd0;
    chk("mrst_sdo", {31'd0, sdo}, 32'd0);
    chk("mrst_busy", {31'd0, busy}, 32'd0);
    chk("mrst_count", {24'd0, frame_count}, 32'd0);
    viol = 0;
    for (int i = 0; i < 8; i++) begin
      sck = 1'b0;
      repeat (8) @(negedge clock);
      if (busy !== 1'b0 || sdo !== 1'b0) viol++;
      sck = 1'b1;
      repeat (8) @(negedge clock);
      if (busy !== 1'b0 || sdo !== 1'b0) viol++;
    end
    chk("mrst_nostart", viol, 0);
    chk("mrst_pulses", (done_n - d0) + (err_n - e0), 0);
    cs = 1'b1;
    repeat (12) @(negedge clock);
    frame_check("after_rst", 16'hC0DE, 16'hC0DE, 0, 16, 32'h0000C0DE, 1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
